instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage; successor to the per-format combinational U-type decoders.
- Covers all base formats (R/I/S/B/U/J) in one block.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer and a synchronous flush.
- Sits between fetch (instruction + PC) and the register-read/execute stage.

Parameters:
- XLEN, 32, datapath width; immediates and PC are sign-/zero-sized to XLEN (XLEN >= 32).
- ALU_OP_W, 4, width of the alu_op field; must match the shared ALU opcode constants.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  drop all buffered entries; synchronous.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  passed-through PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when the format does not use the field.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_alu_op  out  ALU_OP_W  ALU operation code.
- out_fmt  out  3  format code (R/I/S/B/U/J/NONE).
- out_use_pc  out  1  ALU operand A is the PC (AUIPC, JAL).
- out_wb_en  out  1  writes rd; forced 0 when rd==0 or when illegal.
- out_illegal  out  1  opcode, funct3 or funct7 combination is not RV32I.

Behaviour:
- Reset (async assert, released on clk): out_valid=0, all out_* data=0, both buffer entries empty, in_ready=1.
- Handshake:
  - Transfer occurs when valid&&ready on the same rising edge.
  - out_* are stable while out_valid&&!out_ready.
  - in_ready is a registered signal: in_ready = !skid_valid. It never depends combinationally on out_ready.
- Buffer: main output register plus one skid register.
  - Empty, accept: main is loaded; out_valid=1 the next cycle (latency 1).
  - Main full, out_ready=0, accept: the entry goes to skid; in_ready drops next cycle.
  - Main consumed while skid is full: skid moves to main and in_ready rises next cycle.
  - Consume and accept in the same cycle with skid empty: main reloads; no bubble, full throughput.
  - Order is strictly FIFO.
- Decode is combinational on in_instr; the result is registered on accept.
  - LUI imm = {instr[31:12],12'b0} sign-extended to XLEN; alu_op=ALU_PASS_B.
  - AUIPC: same imm, alu_op=ALU_ADD, use_pc=1.
  - I/S/B/J immediates follow the RV32I bit scatter. B and J have bit 0 = 0.
  - SRAI/SRLI/SLLI: imm=shamt (instr[24:20]), zero-extended. instr[30] selects SRA; other funct7 values are illegal.
  - JAL/JALR: alu_op=ALU_ADD, wb_en follows rd.
  - Loads/stores: alu_op=ALU_ADD (address calculation).
  - Branches: alu_op is the compare code from funct3; funct3 010/011 are illegal.
- Illegal (including all-zero instruction): out_illegal=1, wb_en=0, rd/rs1/rs2=0, imm=0, fmt=NONE. The entry is still delivered with out_valid so the trap logic sees it.
- Flush:
  - Next edge: both entries are emptied, out_valid=0, in_ready=1.
  - An in_valid offered in the same cycle as flush is dropped, even if in_ready=1.
  - An out_ready in the same cycle as flush is irrelevant.
- Reset mid-stream: everything is discarded immediately (async) and no partial entry remains.
- rd==0 on any writing instruction: wb_en=0; out_rd still reports 0.

Decomposition:
- Shared include (extend alu_opcode.v): ALU_* codes sized to ALU_OP_W, with ALU_ADD kept at its existing value; OPC_* 7-bit opcodes; FMT_* 3-bit format codes.
- One sub-module, instr_decode_comb: purely combinational instr -> {rd,rs1,rs2,imm,alu_op,fmt,use_pc,wb_en,illegal}.
- instr_decode_stage holds only the handshake, skid buffer and flush logic.

Test Plan:
- LUI 0xABCDE2B7, pc 0x100, out_ready=1 -> one cycle later: rd=5, imm=0xABCDE000, fmt=U, use_pc=0, wb_en=1, out_pc=0x100.
- AUIPC 0x12345397 -> rd=7, imm=0x12345000, alu_op=ALU_ADD, use_pc=1. Then ADDI 0xFFF00093 -> rd=1, rs1=0, imm=0xFFFFFFFF, fmt=I.
- BEQ 0xFE000EE3 -> fmt=B, rs1=rs2=0, imm=0xFFFFFFFC, wb_en=0.
- Backpressure: out_ready=0, offer A,B,C back-to-back -> A and B accepted, in_ready=0 while C is held. Raise out_ready -> A,B,C emerge in order with no duplicates or loss.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction never appears.
- Illegal 0x00000000 and SRAI with funct7=0x10 -> out_valid=1, illegal=1, wb_en=0, imm=0. Async rst pulse mid-stream -> outputs zero immediately.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - shared ALU, opcode and format codes for the RV32I decode stage
package instr_decode_stage_pkg;

    localparam int ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 4'd9;
    localparam logic [ALU_W-1:0] ALU_PASS_B = 4'd10;
    localparam logic [ALU_W-1:0] ALU_EQ     = 4'd11;
    localparam logic [ALU_W-1:0] ALU_NE     = 4'd12;
    localparam logic [ALU_W-1:0] ALU_GE     = 4'd13;
    localparam logic [ALU_W-1:0] ALU_GEU    = 4'd14;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface instr_decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [4:0]          out_rd;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [XLEN-1:0]     out_imm;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [2:0]          out_fmt;
    logic                out_use_pc;
    logic                out_wb_en;
    logic                out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_alu_op, out_fmt, out_use_pc, out_wb_en, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_alu_op, out_fmt, out_use_pc, out_wb_en, out_illegal
    );
endinterface

// File: rtl/instr_decode_stage_comb.sv
// rtl/instr_decode_stage_comb.sv - combinational RV32I field, immediate and ALU-op decoder
module instr_decode_comb
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic [31:0]         instr,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          fmt,
    output logic                use_pc,
    output logic                wb_en,
    output logic                illegal
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    logic             ill, wr, use_rd, use_rs1, use_rs2, pc_a;
    logic [31:0]      imm32;
    logic [ALU_W-1:0] alu;
    fmt_e             fmt_d;

    always_comb begin
        ill     = 1'b0;
        wr      = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        pc_a    = 1'b0;
        imm32   = 32'b0;
        alu     = ALU_ADD;
        fmt_d   = FMT_NONE;
        case (opc)
            OPC_LUI: begin
                fmt_d = FMT_U; imm32 = imm_u; alu = ALU_PASS_B; use_rd = 1'b1; wr = 1'b1;
            end
            OPC_AUIPC: begin
                fmt_d = FMT_U; imm32 = imm_u; pc_a = 1'b1; use_rd = 1'b1; wr = 1'b1;
            end
            OPC_JAL: begin
                fmt_d = FMT_J; imm32 = imm_j; pc_a = 1'b1; use_rd = 1'b1; wr = 1'b1;
            end
            OPC_JALR: begin
                fmt_d = FMT_I; imm32 = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt_d = FMT_B; imm32 = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'b000:  alu = ALU_EQ;
                    3'b001:  alu = ALU_NE;
                    3'b100:  alu = ALU_SLT;
                    3'b101:  alu = ALU_GE;
                    3'b110:  alu = ALU_SLTU;
                    3'b111:  alu = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt_d = FMT_I; imm32 = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                fmt_d = FMT_S; imm32 = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ill = (f3[2] || f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                fmt_d = FMT_I; imm32 = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
                case (f3)
                    3'b000: alu = ALU_ADD;
                    3'b010: alu = ALU_SLT;
                    3'b011: alu = ALU_SLTU;
                    3'b100: alu = ALU_XOR;
                    3'b110: alu = ALU_OR;
                    3'b111: alu = ALU_AND;
                    3'b001: begin
                        alu = ALU_SLL; imm32 = imm_sh; ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        // instr[30] picks arithmetic shift; every other funct7 bit must be clear
                        alu   = instr[30] ? ALU_SRA : ALU_SRL;
                        imm32 = imm_sh;
                        ill   = ({f7[6], f7[4:0]} != 6'b0);
                    end
                endcase
            end
            OPC_OP: begin
                fmt_d = FMT_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  alu = ALU_ADD;
                        3'b001:  alu = ALU_SLL;
                        3'b010:  alu = ALU_SLT;
                        3'b011:  alu = ALU_SLTU;
                        3'b100:  alu = ALU_XOR;
                        3'b101:  alu = ALU_SRL;
                        3'b110:  alu = ALU_OR;
                        default: alu = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    alu = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                fmt_d = FMT_I; imm32 = imm_i; ill = (f3 != 3'b000);
            end
            OPC_SYSTEM: begin
                // only ECALL/EBREAK; imm keeps instr[31:20] so the trap logic can tell them apart
                fmt_d = FMT_I; imm32 = imm_i;
                ill   = (instr != 32'h0000_0073) && (instr != 32'h0010_0073);
            end
            default: ill = 1'b1;
        endcase
    end

    assign illegal = ill;
    assign rd      = (ill || !use_rd)  ? 5'd0 : instr[11:7];
    assign rs1     = (ill || !use_rs1) ? 5'd0 : instr[19:15];
    assign rs2     = (ill || !use_rs2) ? 5'd0 : instr[24:20];
    assign imm     = ill ? '0 : XLEN'($signed(imm32));
    assign alu_op  = ill ? ALU_OP_W'(ALU_ADD) : ALU_OP_W'(alu);
    assign fmt     = ill ? FMT_NONE : fmt_d;
    assign use_pc  = pc_a && !ill;
    assign wb_en   = wr && !ill && (instr[11:7] != 5'd0);

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered RV32I decode stage with valid/ready, 2-entry skid buffer and flush
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = ALU_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          fmt;
        logic                use_pc;
        logic                wb_en;
        logic                illegal;
    } entry_t;

    entry_t dec, main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   accept, consume;

    assign dec.pc = bus.in_pc;

    instr_decode_comb #(
        .XLEN     (XLEN),
        .ALU_OP_W (ALU_OP_W)
    ) u_dec (
        .instr   (bus.in_instr),
        .rd      (dec.rd),
        .rs1     (dec.rs1),
        .rs2     (dec.rs2),
        .imm     (dec.imm),
        .alu_op  (dec.alu_op),
        .fmt     (dec.fmt),
        .use_pc  (dec.use_pc),
        .wb_en   (dec.wb_en),
        .illegal (dec.illegal)
    );

    // in_ready comes straight from a flop so fetch never sees a path from out_ready
    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid && !flush;
    assign consume      = main_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || consume) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) main_q <= dec;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign bus.out_valid   = main_valid;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_alu_op  = main_q.alu_op;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_use_pc  = main_q.use_pc;
    assign bus.out_wb_en   = main_q.wb_en;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed self-checking bench for instr_decode_stage
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   passed = 0;
    int   total  = 0;

    instr_decode_stage_if #(.XLEN(32), .ALU_OP_W(4)) bus ();

    instr_decode_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_imm", bus.out_imm, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // streaming at full throughput
        bus.out_ready = 1'b1;
        offer(32'hABCDE2B7, 32'h100);
        tick();
        check("lui_valid", bus.out_valid, 1);
        check("lui_rd", bus.out_rd, 5);
        check("lui_imm", bus.out_imm, 32'hABCDE000);
        check("lui_fmt", bus.out_fmt, 5);
        check("lui_alu", bus.out_alu_op, 10);
        check("lui_use_pc", bus.out_use_pc, 0);
        check("lui_wb", bus.out_wb_en, 1);
        check("lui_pc", bus.out_pc, 32'h100);
        offer(32'h12345397, 32'h104);
        tick();
        check("auipc_rd", bus.out_rd, 7);
        check("auipc_imm", bus.out_imm, 32'h12345000);
        check("auipc_alu", bus.out_alu_op, 0);
        check("auipc_use_pc", bus.out_use_pc, 1);
        check("auipc_pc", bus.out_pc, 32'h104);
        offer(32'hFFF00093, 32'h108);
        tick();
        check("addi_rd", bus.out_rd, 1);
        check("addi_rs1", bus.out_rs1, 0);
        check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        check("addi_fmt", bus.out_fmt, 2);
        offer(32'hFE000EE3, 32'h10C);
        tick();
        check("beq_fmt", bus.out_fmt, 4);
        check("beq_rs1", bus.out_rs1, 0);
        check("beq_rs2", bus.out_rs2, 0);
        check("beq_imm", bus.out_imm, 32'hFFFFFFFC);
        check("beq_wb", bus.out_wb_en, 0);
        check("beq_alu", bus.out_alu_op, 11);
        offer(32'h008000EF, 32'h110);
        tick();
        check("jal_fmt", bus.out_fmt, 6);
        check("jal_imm", bus.out_imm, 8);
        check("jal_use_pc", bus.out_use_pc, 1);
        check("jal_wb", bus.out_wb_en, 1);
        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", bus.out_valid, 0);

        // backpressure: A into main, B into skid, C held off
        bus.out_ready = 1'b0;
        offer(32'h002081B3, 32'h200);
        tick();
        check("bp_a_in_ready", bus.in_ready, 1);
        offer(32'h40208233, 32'h204);
        tick();
        check("bp_b_in_ready", bus.in_ready, 0);
        check("bp_a_pc", bus.out_pc, 32'h200);
        offer(32'h00812283, 32'h208);
        tick();
        check("bp_hold_in_ready", bus.in_ready, 0);
        check("bp_hold_pc", bus.out_pc, 32'h200);
        check("bp_a_rd", bus.out_rd, 3);
        check("bp_a_rs2", bus.out_rs2, 2);
        bus.out_ready = 1'b1;
        tick();
        check("bp_b_valid", bus.out_valid, 1);
        check("bp_b_pc", bus.out_pc, 32'h204);
        check("bp_b_alu", bus.out_alu_op, 1);
        check("bp_b_in_ready", bus.in_ready, 1);
        tick();
        check("bp_c_pc", bus.out_pc, 32'h208);
        check("bp_c_rd", bus.out_rd, 5);
        check("bp_c_imm", bus.out_imm, 8);
        bus.in_valid = 1'b0;
        tick();
        check("bp_end_valid", bus.out_valid, 0);

        // flush with both entries full and an offer pending
        bus.out_ready = 1'b0;
        offer(32'h002081B3, 32'h300);
        tick();
        offer(32'h40208233, 32'h304);
        tick();
        check("fl_full_in_ready", bus.in_ready, 0);
        offer(32'h00812283, 32'h308);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        check("fl_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);
        offer(32'hFFF00093, 32'h30C);
        tick();
        check("fl_drop_ready_valid", bus.out_valid, 0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("fl_after_valid", bus.out_valid, 0);

        // illegal encodings and shift immediates
        offer(32'h00000000, 32'h400);
        tick();
        check("ill0_valid", bus.out_valid, 1);
        check("ill0_illegal", bus.out_illegal, 1);
        check("ill0_wb", bus.out_wb_en, 0);
        check("ill0_imm", bus.out_imm, 0);
        check("ill0_fmt", bus.out_fmt, 0);
        offer(32'h20315093, 32'h404);
        tick();
        check("illsrai_illegal", bus.out_illegal, 1);
        check("illsrai_wb", bus.out_wb_en, 0);
        check("illsrai_imm", bus.out_imm, 0);
        check("illsrai_rd", bus.out_rd, 0);
        offer(32'h40315093, 32'h408);
        tick();
        check("srai_illegal", bus.out_illegal, 0);
        check("srai_imm", bus.out_imm, 3);
        check("srai_alu", bus.out_alu_op, 7);
        check("srai_rs1", bus.out_rs1, 2);
        offer(32'h00000013, 32'h40C);
        tick();
        check("nop_wb", bus.out_wb_en, 0);
        check("nop_rd", bus.out_rd, 0);
        check("nop_illegal", bus.out_illegal, 0);

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        offer(32'hABCDE2B7, 32'h500);
        tick();
        offer(32'h12345397, 32'h504);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_pc", bus.out_pc, 0);
        check("arst_imm", bus.out_imm, 0);
        check("arst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("arst_after_valid", bus.out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
